vport_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one 24-bit shared datapath port fed by three requesters, for example the scalar unit, the vector lanes and the load unit.
- Drives the 2-bit select of the downstream three-input mux. Select 2'b11 means idle, and the mux then outputs zero.
- Accepts bursts from the granted requester and registers each beat into a single output stage with a valid/ready handshake.
- Rotates ownership fairly between requesters and caps each grant at MAX_BURST beats.

---
 rtl/vport_pkg.sv | 14 +
 rtl/rr_pick3.sv | 33 +++
 rtl/vport_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_vport_rr_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vport_pkg.sv
// Shared types and constants for the vector-port round-robin arbiter.
package vport_pkg;

  typedef enum logic [0:0] {IDLE, GRANT} arb_state_t;

  localparam logic [1:0] SEL_IDLE = 2'b11;
  localparam int unsigned NREQ = 3;

  // Modulo-3 increment of a requester index.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters, starting the scan at ptr.
module rr_pick3
  import vport_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic [1:0]      ptr,
  output logic [1:0]      winner,
  output logic            found
);

  logic [1:0] c0, c1, c2;
  logic [3:0] valid_pad;

  assign c0        = ptr;
  assign c1        = next_idx(c0);
  assign c2        = next_idx(c1);
  assign valid_pad = {1'b0, valid};

  always_comb begin
    winner = 2'd0;
    found  = 1'b1;
    if (valid_pad[c0]) begin
      winner = c0;
    end else if (valid_pad[c1]) begin
      winner = c1;
    end else if (valid_pad[c2]) begin
      winner = c2;
    end else begin
      found = 1'b0;
    end
  end

endmodule

// File: rtl/vport_rr_arbiter.sv
// Round-robin arbiter for a shared datapath port: grants bursts of up to MAX_BURST beats
// and registers each accepted beat into a single valid/ready output stage.
module vport_rr_arbiter
  import vport_pkg::*;
#(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_last,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  output logic [NREQ-1:0]  req_ready,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  arb_state_t       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;

  logic [1:0]       pick_idx;
  logic             pick_found;
  logic [3:0]       valid_pad, last_pad, ready_vec;
  logic             owner_valid, owner_last, stage_free, xfer, cap_hit;
  logic [4:0]       cnt_inc;
  logic [WIDTH-1:0] owner_data;

  rr_pick3 u_pick (
    .valid  (req_valid),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .found  (pick_found)
  );

  assign valid_pad   = {1'b0, req_valid};
  assign last_pad    = {1'b0, req_last};
  assign owner_valid = valid_pad[owner_q];
  assign owner_last  = last_pad[owner_q];
  assign stage_free  = !out_valid_q || out_ready;
  assign xfer        = (state_q == GRANT) && owner_valid && stage_free;
  assign cnt_inc     = {1'b0, beat_cnt_q} + 5'd1;
  assign cap_hit     = (cnt_inc == 5'(MAX_BURST));

  always_comb begin
    case (owner_q)
      2'd0:    owner_data = req_data0;
      2'd1:    owner_data = req_data1;
      2'd2:    owner_data = req_data2;
      default: owner_data = '0;
    endcase
  end

  // State register, including the output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      owner_q     <= 2'd0;
      beat_cnt_q  <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          owner_d    = pick_idx;
          beat_cnt_d = 4'd0;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_d = cnt_inc[3:0];
        end
        // Last beat, burst cap, or an owner that walked away all end the grant.
        if ((xfer && (owner_last || cap_hit)) || !owner_valid) begin
          state_d    = IDLE;
          ptr_d      = next_idx(owner_q);
          beat_cnt_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = owner_data;
      out_src_d   = owner_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output decode.
  always_comb begin
    sel       = SEL_IDLE;
    ready_vec = 4'd0;
    if (state_q == GRANT) begin
      sel                = owner_q;
      ready_vec[owner_q] = stage_free;
    end
    req_ready = ready_vec[NREQ-1:0];
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_vport_rr_arbiter.sv
// Directed bench for vport_rr_arbiter: per-cycle compare against a behavioural model plus
// hand-computed beat sequences for each scenario.
module tb_vport_rr_arbiter;

  localparam int W    = 24;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    req_valid, req_last, req_ready;
  logic [W-1:0]  req_data0, req_data1, req_data2, out_data;
  logic [1:0]    sel, out_src;
  logic          out_valid, out_ready;

  vport_rr_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_ready (req_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Requester beat queues: {last, data}.
  logic [W:0]   q0[$], q1[$], q2[$];
  logic [2:0]   en;
  logic [W+1:0] obs[$], expq[$];

  // Behavioural model: granted flag, owner, pointer, beats in this grant, output stage.
  bit           m_grant;
  int           m_owner, m_ptr, m_cnt, m_src;
  bit           m_ov;
  logic [W-1:0] m_od;

  function automatic logic [W-1:0] data_of(input int i);
    return (i == 0) ? req_data0 : (i == 1) ? req_data1 : req_data2;
  endfunction

  function automatic int pick(input int p);
    for (int k = 0; k < 3; k++) begin
      if (req_valid[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  function automatic bit m_xfer();
    return m_grant && req_valid[m_owner] && (!m_ov || out_ready);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_grant <= 1'b0; m_owner <= 0; m_ptr <= 0; m_cnt <= 0;
      m_ov <= 1'b0; m_od <= '0; m_src <= 0;
    end else if (!m_grant) begin
      if (pick(m_ptr) >= 0) begin
        m_grant <= 1'b1; m_owner <= pick(m_ptr); m_cnt <= 0;
      end
      if (out_ready) m_ov <= 1'b0;
    end else begin
      if (m_xfer()) begin
        m_ov <= 1'b1; m_od <= data_of(m_owner); m_src <= m_owner; m_cnt <= m_cnt + 1;
      end else if (out_ready) begin
        m_ov <= 1'b0;
      end
      if ((m_xfer() && (req_last[m_owner] || m_cnt + 1 == MAXB)) || !req_valid[m_owner]) begin
        m_grant <= 1'b0; m_ptr <= (m_owner + 1) % 3;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    req_valid[0] = en[0] && (q0.size() != 0);
    req_valid[1] = en[1] && (q1.size() != 0);
    req_valid[2] = en[2] && (q2.size() != 0);
    req_last[0]  = (q0.size() != 0) ? q0[0][W] : 1'b0;
    req_last[1]  = (q1.size() != 0) ? q1[0][W] : 1'b0;
    req_last[2]  = (q2.size() != 0) ? q2[0][W] : 1'b0;
    req_data0    = (q0.size() != 0) ? q0[0][W-1:0] : '0;
    req_data1    = (q1.size() != 0) ? q1[0][W-1:0] : '0;
    req_data2    = (q2.size() != 0) ? q2[0][W-1:0] : '0;
  endtask

  task automatic step();
    logic [2:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    if (rst_n && out_valid && out_ready) obs.push_back({out_src, out_data});
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (hs[0]) void'(q0.pop_front());
      if (hs[1]) void'(q1.pop_front());
      if (hs[2]) void'(q2.pop_front());
    end
    drive();
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((q0.size() + q1.size() + q2.size() != 0 || out_valid) && k < 80) begin
      step();
      k++;
    end
    step();
    step();
    chk({name, "_timeout"}, 32'(k < 80), 32'd1);
  endtask

  task automatic check_obs(input string name);
    chk({name, "_count"}, obs.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      chk(name, (i < obs.size()) ? 32'(obs[i]) : 32'hffff_ffff, 32'(expq[i]));
    end
    obs.delete();
    expq.delete();
  endtask

  function automatic logic [W+1:0] bt(input int src, input int data);
    return {src[1:0], data[W-1:0]};
  endfunction

  initial begin
    en = 3'b111; out_ready = 1'b1; rst_n = 1'b0;

    fork
      forever begin
        @(negedge clk);
        chk("sel", sel, m_grant ? m_owner : 32'd3);
        chk("req_ready", req_ready,
            m_grant ? (32'(!m_ov || out_ready) << m_owner) : 32'd0);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_src", out_src, m_src);
      end
    join_none

    // Reset with every requester valid; then fairness over single-beat bursts.
    q0 = '{{1'b1, 24'hA00001}, {1'b1, 24'hA00002}};
    q1 = '{{1'b1, 24'hB00001}, {1'b1, 24'hB00002}};
    q2 = '{{1'b1, 24'hC00001}, {1'b1, 24'hC00002}};
    drive();
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel", sel, 3);
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    drain("fair");
    expq = '{bt(0, 'hA00001), bt(1, 'hB00001), bt(2, 'hC00001),
             bt(0, 'hA00002), bt(1, 'hB00002), bt(2, 'hC00002)};
    check_obs("fair_seq");

    // Burst cap: six beats from requester 1, requester 2 waiting.
    for (int i = 0; i < 6; i++) q1.push_back({1'b0, 24'(32'h10 + i)});
    q2.push_back({1'b1, 24'h000020});
    drive();
    drain("cap");
    expq = '{bt(1, 'h10), bt(1, 'h11), bt(1, 'h12), bt(1, 'h13),
             bt(2, 'h20), bt(1, 'h14), bt(1, 'h15)};
    check_obs("cap_seq");

    // Backpressure for five cycles mid-burst.
    q0 = '{{1'b0, 24'h30}, {1'b0, 24'h31}, {1'b0, 24'h32}, {1'b1, 24'h33}};
    drive();
    repeat (3) step();
    out_ready = 1'b0;
    repeat (5) begin
      step();
      chk("bp_hold_data", out_data, 24'h31);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_ready_low", req_ready, 0);
    end
    out_ready = 1'b1;
    drain("bp");
    expq = '{bt(0, 'h30), bt(0, 'h31), bt(0, 'h32), bt(0, 'h33)};
    check_obs("bp_seq");

    // Owner abandons after one beat; pending requester 2 takes over.
    q1 = '{{1'b0, 24'h40}, {1'b0, 24'h41}, {1'b0, 24'h42}};
    q2 = '{{1'b1, 24'h50}};
    drive();
    repeat (2) step();
    en[1] = 1'b0;
    drive();
    step();
    chk("abandon_idle_sel", sel, 3);
    step();
    chk("abandon_next_sel", sel, 2);
    en[1] = 1'b1;
    drive();
    drain("abandon");
    expq = '{bt(1, 'h40), bt(2, 'h50), bt(1, 'h41), bt(1, 'h42)};
    check_obs("abandon_seq");

    // Reset while a beat sits in the output stage.
    q0 = '{{1'b0, 24'h60}, {1'b0, 24'h61}, {1'b1, 24'h62}};
    drive();
    step();
    out_ready = 1'b0;
    step();
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    q1 = '{{1'b1, 24'h70}};
    q2 = '{{1'b1, 24'h80}};
    drive();
    step();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sel", sel, 3);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drain("midrst");
    expq = '{bt(0, 'h61), bt(0, 'h62), bt(1, 'h70), bt(2, 'h80)};
    check_obs("midrst_seq");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
